switch_bounce_gen: RTL and testbench

- Generates switch-contact bounce on a clean logic level, for hardware-in-the-loop exercise of our debouncer FSMDs on the FPGA board and in simulation.
- Takes a clean level `i_level`. Each change produces a burst of pseudo-random toggles on `o_sw`, lasting a fixed duration, after which `o_sw` settles to the new level.
- Sits upstream of a debouncer: the stimulus source for that receiver.

---
 rtl/switch_bounce_gen.sv | 136 +++++++++++++
 tb/tb_switch_bounce_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
`default_nettype none
// ============================================================================
//  Module      : switch_bounce_gen
//  Description : Turns a clean level into a contact-bounce waveform. Each
//                change of i_level starts a burst of pseudo-random toggles on
//                o_sw lasting BOUNCE_CYCLES clocks, after which o_sw settles
//                to the new level and o_settled pulses for one cycle.
//                Optional feature macro: SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
//                (adds o_toggle_count, transitions seen in the last burst).
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_bounce_gen #(
    parameter int          BOUNCE_CYCLES = 100_000,
    parameter int          TOGGLE_W      = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_level,
    output logic        o_sw,
    output logic        o_busy,
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
    output logic [15:0] o_toggle_count,
`endif
    output logic        o_settled
);

    localparam int                   c_DUR_W      = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [c_DUR_W-1:0]   c_DUR_RELOAD = c_DUR_W'(BOUNCE_CYCLES - 1);
    localparam logic [c_DUR_W-1:0]   c_DUR_ZERO   = '0;
    localparam logic [TOGGLE_W:0]    c_GAP_ONE    = (TOGGLE_W + 1)'(1);

    typedef enum logic [1:0] {
        e_low  = 2'd0,
        e_rise = 2'd1,
        e_high = 2'd2,
        e_fall = 2'd3
    } state_t;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [c_DUR_W-1:0]   r_dur;
    logic [TOGGLE_W:0]    r_gap;
    logic                 r_target;

    logic [TOGGLE_W:0]    w_gap_reload;
    logic [15:0]          w_lfsr_next;

    // Gap until the next toggle is 1..2^TOGGLE_W cycles, taken from the LFSR.
    assign w_gap_reload = (TOGGLE_W + 1)'(r_lfsr[TOGGLE_W-1:0]) + c_GAP_ONE;

    // Right-shifting Galois LFSR, taps for x^16+x^14+x^13+x^11+1.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
    logic [15:0] w_cnt_inc;
    // Saturating increment so a very long burst never wraps the count.
    assign w_cnt_inc = (o_toggle_count == 16'hFFFF) ? o_toggle_count : o_toggle_count + 16'd1;
`endif

    // Burst sequencer: idle levels, bounce bursts, retarget and settle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= e_low;
            r_lfsr    <= LFSR_SEED;
            r_dur     <= '0;
            r_gap     <= '0;
            r_target  <= 1'b0;
            o_sw      <= 1'b0;
            o_busy    <= 1'b0;
            o_settled <= 1'b0;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
            o_toggle_count <= 16'd0;
`endif
        end else begin
            r_lfsr    <= w_lfsr_next;
            o_settled <= 1'b0;
            case (r_state)
                e_low, e_high: begin
                    // A level change starts a burst with an immediate first edge.
                    if (i_level != r_target) begin
                        r_state  <= i_level ? e_rise : e_fall;
                        r_target <= i_level;
                        o_sw     <= ~o_sw;
                        r_dur    <= c_DUR_RELOAD;
                        r_gap    <= w_gap_reload;
                        o_busy   <= 1'b1;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
                        o_toggle_count <= 16'd1;
`endif
                    end
                end
                e_rise, e_fall: begin
                    if (i_level != r_target) begin
                        // Level reversed mid-burst: restart timing, no forced edge.
                        r_state  <= (r_state == e_rise) ? e_fall : e_rise;
                        r_target <= ~r_target;
                        r_dur    <= c_DUR_RELOAD;
                        r_gap    <= w_gap_reload;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
                        o_toggle_count <= 16'd0;
`endif
                    end else if (r_dur == c_DUR_ZERO) begin
                        // Burst over: land on the target level, settle wins over a toggle.
                        o_sw      <= r_target;
                        r_state   <= r_target ? e_high : e_low;
                        o_settled <= 1'b1;
                        o_busy    <= 1'b0;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
                        if (o_sw != r_target) begin
                            o_toggle_count <= w_cnt_inc;
                        end
`endif
                    end else begin
                        r_dur <= r_dur - c_DUR_W'(1);
                        if (r_gap == c_GAP_ONE) begin
                            o_sw  <= ~o_sw;
                            r_gap <= w_gap_reload;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
                            o_toggle_count <= w_cnt_inc;
`endif
                        end else begin
                            r_gap <= r_gap - c_GAP_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= e_low;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_bounce_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_bounce_gen
//  Description : Self-checking bench for switch_bounce_gen with
//                BOUNCE_CYCLES=20, TOGGLE_W=2. A timeline model predicts
//                o_sw/o_busy/o_settled every cycle; directed checks pin key
//                instants; a bench-side tick debouncer exercises loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_bounce_gen;

    localparam int BC = 20;
    localparam int TW = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_level = 1'b0;
    logic o_sw, o_busy, o_settled;
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
    logic [15:0] o_toggle_count;
`endif

    switch_bounce_gen #(
        .BOUNCE_CYCLES (BC),
        .TOGGLE_W      (TW),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_level        (i_level),
        .o_sw           (o_sw),
        .o_busy         (o_busy),
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
        .o_toggle_count (o_toggle_count),
`endif
        .o_settled      (o_settled)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ---------------- timeline model ----------------
    logic        m_sw = 1'b0, m_busy = 1'b0, m_settled = 1'b0, m_target = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_end = 0, m_next = 0, m_cnt = 0, n_edge = 0;

    initial begin
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                m_sw = 1'b0; m_busy = 1'b0; m_settled = 1'b0; m_target = 1'b0;
                m_lfsr = 16'hACE1; m_cnt = 0;
            end else begin
                int g;
                g = int'(m_lfsr % 16'(1 << TW)) + 1;
                n_edge++;
                m_settled = 1'b0;
                if (!m_busy) begin
                    if (i_level != m_target) begin
                        m_target = i_level; m_sw = ~m_sw; m_busy = 1'b1;
                        m_end = n_edge + BC; m_next = n_edge + g; m_cnt = 1;
                    end
                end else if (i_level != m_target) begin
                    m_target = i_level; m_end = n_edge + BC; m_next = n_edge + g; m_cnt = 0;
                end else if (n_edge == m_end) begin
                    if (m_sw != m_target && m_cnt < 65535) m_cnt++;
                    m_sw = m_target; m_busy = 1'b0; m_settled = 1'b1;
                end else if (n_edge == m_next) begin
                    m_sw = ~m_sw; m_next = n_edge + g;
                    if (m_cnt < 65535) m_cnt++;
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    // ---------------- compare + run-length + loopback ----------------
    logic chk_runs = 1'b0;
    logic prev_sw = 1'b0, prev_busy = 1'b0;
    int   run = 0, toggles = 0, edges = 0;

    logic lb_on = 1'b0, db = 1'b0;
    int   tcnt = 0, db_changes = 0, db_rises = 0;

    initial begin
        forever begin
            @(negedge i_clk);
            check("model_sw", {31'd0, o_sw}, {31'd0, m_sw});
            check("model_busy", {31'd0, o_busy}, {31'd0, m_busy});
            check("model_settled", {31'd0, o_settled}, {31'd0, m_settled});
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
            check("model_tcount", {16'd0, o_toggle_count}, m_cnt);
`endif
            if (!i_rst) begin
                if (o_busy && !prev_busy) begin
                    run = 1; toggles = 0; edges = 1;
                end else if (o_busy && o_sw != prev_sw) begin
                    if (chk_runs) check("gap_run_ok", (run >= 1 && run <= 4), 1);
                    run = 1; toggles++; edges++;
                end else if (o_busy) begin
                    run++;
                end else if (prev_busy) begin
                    if (o_sw != prev_sw) edges++;
                    if (chk_runs) begin
                        check("burst_has_toggle", (toggles >= 1), 1);
`ifdef SWITCH_BOUNCE_GEN_TOGGLE_COUNT_EN
                        check("edge_count", {16'd0, o_toggle_count}, edges);
`endif
                    end
                end
                if (lb_on) begin
                    tcnt++;
                    if (tcnt == 25) begin
                        tcnt = 0;
                        if (o_sw != db) begin
                            db = o_sw; db_changes++;
                            if (o_sw) db_rises++;
                        end
                    end
                end
            end
            prev_sw = o_sw; prev_busy = o_busy;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int pulses;
        repeat (3) tick();
        i_rst = 1'b0;
        check("reset_sw", {31'd0, o_sw}, 0);
        check("reset_busy", {31'd0, o_busy}, 0);
        check("reset_settled", {31'd0, o_settled}, 0);
        repeat (2) tick();

        // Rise
        i_level = 1'b1;
        tick();
        check("rise_first_edge", {31'd0, o_sw}, 1);
        check("rise_busy", {31'd0, o_busy}, 1);
        repeat (19) tick();
        check("rise_k19_no_settle", {31'd0, o_settled}, 0);
        tick();
        check("rise_settle_sw", {31'd0, o_sw}, 1);
        check("rise_settle_pulse", {31'd0, o_settled}, 1);
        check("rise_settle_busy", {31'd0, o_busy}, 0);
        tick();
        check("rise_pulse_end", {31'd0, o_settled}, 0);
        check("rise_idle_busy", {31'd0, o_busy}, 0);
        repeat (5) tick();
        check("rise_stable", {31'd0, o_sw}, 1);

        i_level = 1'b0;
        repeat (25) tick();

        // Glitch abort
        i_level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("glitch_no_settle", {31'd0, o_settled}, 0);
        end
        i_level = 1'b0;
        pulses = 0;
        tick();
        check("glitch_busy", {31'd0, o_busy}, 1);
        pulses += int'(o_settled);
        repeat (19) begin tick(); pulses += int'(o_settled); end
        tick();
        check("glitch_settle_sw", {31'd0, o_sw}, 0);
        check("glitch_settle_pulse", {31'd0, o_settled}, 1);
        pulses += int'(o_settled);
        tick();
        pulses += int'(o_settled);
        check("glitch_single_pulse", pulses, 1);

        // Random rise/fall bursts, runs checked by the compare process
        repeat (5) tick();
        chk_runs = 1'b1;
        for (int e = 0; e < 50; e++) begin
            i_level = ~i_level;
            repeat ($urandom_range(22, 30)) tick();
        end
        chk_runs = 1'b0;

        // Asynchronous reset in the middle of a burst
        i_level = 1'b1;
        repeat (7) tick();
        check("pre_reset_busy", {31'd0, o_busy}, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_sw", {31'd0, o_sw}, 0);
        check("async_rst_busy", {31'd0, o_busy}, 0);
        check("async_rst_settled", {31'd0, o_settled}, 0);
        i_level = 1'b0;
        tick();
        i_rst = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", {30'd0, o_sw, o_busy}, 0);

        // Loopback through a tick-sampled debouncer
        db = 1'b0; tcnt = 0; lb_on = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_level = ~i_level;
            repeat (60) tick();
        end
        lb_on = 1'b0;
        check("loop_db_changes", db_changes, 6);
        check("loop_db_rises", db_rises, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
